// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal BHT + direct-mapped BTB branch predictor with resolve/mispredict logic
module branch_predictor #(
    parameter int BHT_IDX_W = 6,
    parameter int BTB_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic [31:0] ex_pc,
    input  logic        ex_br_en,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 32 - BTB_IDX_W - 2;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] ST  = 2'b11;

    // Prediction state
    logic [1:0]       bht        [BHT_N];
    logic             btb_valid  [BTB_N];
    logic [TAG_W-1:0] btb_tag    [BTB_N];
    logic [31:0]      btb_target [BTB_N];

    // Fetch-side lookup
    logic [BHT_IDX_W-1:0] if_bht_idx;
    logic [BTB_IDX_W-1:0] if_btb_idx;
    logic [TAG_W-1:0]     if_tag;
    logic                 btb_hit;

    // Execute-side resolve
    logic [BHT_IDX_W-1:0] ex_bht_idx;
    logic [BTB_IDX_W-1:0] ex_btb_idx;
    logic [TAG_W-1:0]     ex_tag;
    logic                 resolve;

    assign if_bht_idx = if_pc[BHT_IDX_W+1:2];
    assign if_btb_idx = if_pc[BTB_IDX_W+1:2];
    assign if_tag     = if_pc[31:BTB_IDX_W+2];

    assign ex_bht_idx = ex_pc[BHT_IDX_W+1:2];
    assign ex_btb_idx = ex_pc[BTB_IDX_W+1:2];
    assign ex_tag     = ex_pc[31:BTB_IDX_W+2];

    assign resolve = ex_valid && ex_is_br;

    // Zero-latency prediction; reads see the arrays before this cycle's update.
    // rst forces not-taken so the arrays' pre-reset contents never leak out.
    always_comb begin
        btb_hit     = btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
        pred_taken  = !rst && btb_hit && bht[if_bht_idx][1];
        pred_target = pred_taken ? btb_target[if_btb_idx] : (if_pc + 32'd4);
    end

    // Mispredict detection and the corrected fetch address
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = ex_br_en ? ex_target : (ex_pc + 32'd4);
        if (resolve) begin
            if (ex_br_en != ex_pred_taken) begin
                mispredict = 1'b1;
            end else if (ex_br_en && (ex_pred_target != ex_target)) begin
                mispredict = 1'b1;
            end
        end
    end

    // BHT: reset to weakly-not-taken, then train the 2-bit counter on each resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= WNT;
            end
        end else if (resolve) begin
            if (ex_br_en) begin
                if (bht[ex_bht_idx] != ST) begin
                    bht[ex_bht_idx] <= bht[ex_bht_idx] + 2'd1;
                end
            end else begin
                if (bht[ex_bht_idx] != SNT) begin
                    bht[ex_bht_idx] <= bht[ex_bht_idx] - 2'd1;
                end
            end
        end
    end

    // BTB valid bits: cleared on reset, set by any taken resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid[i] <= 1'b0;
            end
        end else if (resolve && ex_br_en) begin
            btb_valid[ex_btb_idx] <= 1'b1;
        end
    end

    // BTB tag/target payload: overwritten by taken resolves, contents irrelevant while invalid
    always_ff @(posedge clk) begin
        if (!rst && resolve && ex_br_en) begin
            btb_tag[ex_btb_idx]    <= ex_tag;
            btb_target[ex_btb_idx] <= ex_target;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count      <= 32'd0;
            mispred_count <= 32'd0;
        end else begin
            if (resolve && (br_count != 32'hFFFF_FFFF)) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict && (mispred_count != 32'hFFFF_FFFF)) begin
                mispred_count <= mispred_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector table plus randomized model check for branch_predictor
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_br;
    logic [31:0] ex_pc;
    logic        ex_br_en;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_pass;
    int n_total;

    branch_predictor #(.BHT_IDX_W(6), .BTB_IDX_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_pc          (ex_pc),
        .ex_br_en       (ex_br_en),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] if_pc;
        logic        vld;
        logic        isbr;
        logic [31:0] pc;
        logic        en;
        logic [31:0] tgt;
        logic        ept;
        logic [31:0] eptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mp;
        logic [31:0] e_red;
        logic [31:0] e_brc;
        logic [31:0] e_mpc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic [31:0] ipc, logic v, logic b, logic [31:0] pc,
                                logic en, logic [31:0] tgt, logic ept, logic [31:0] eptgt,
                                logic e_pt, logic [31:0] e_ptgt, logic e_mp, logic [31:0] e_red,
                                logic [31:0] e_brc, logic [31:0] e_mpc);
        vec_t x;
        x.rst = r; x.if_pc = ipc; x.vld = v; x.isbr = b; x.pc = pc; x.en = en; x.tgt = tgt;
        x.ept = ept; x.eptgt = eptgt; x.e_pt = e_pt; x.e_ptgt = e_ptgt; x.e_mp = e_mp;
        x.e_red = e_red; x.e_brc = e_brc; x.e_mpc = e_mpc;
        return x;
    endfunction

    // Behavioural reference: counters as plain integers 0..3, BTB as arrays keyed by arithmetic index
    int          m_cnt [64];
    bit          m_bv  [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [31:0] m_brc, m_mpc;

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 1;
        for (int i = 0; i < 16; i++) m_bv[i] = 0;
        m_brc = 0;
        m_mpc = 0;
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output logic pt, output logic [31:0] tg);
        int bi, ti;
        bit hit;
        bi  = (pc / 4) % 64;
        ti  = (pc / 4) % 16;
        hit = m_bv[ti] && (m_tag[ti] == pc / 64);
        pt  = hit && (m_cnt[bi] >= 2);
        tg  = pt ? m_tgt[ti] : pc + 32'd4;
    endfunction

    function automatic logic m_misp();
        if (!(ex_valid && ex_is_br)) return 1'b0;
        if (ex_br_en != ex_pred_taken) return 1'b1;
        return ex_br_en && (ex_pred_target != ex_target);
    endfunction

    function automatic void m_edge(input logic mp);
        int bi, ti;
        if (rst) begin
            m_reset();
            return;
        end
        if (!(ex_valid && ex_is_br)) return;
        bi = (ex_pc / 4) % 64;
        ti = (ex_pc / 4) % 16;
        if (ex_br_en) begin
            m_cnt[bi] = (m_cnt[bi] == 3) ? 3 : m_cnt[bi] + 1;
            m_bv[ti]  = 1;
            m_tag[ti] = ex_pc / 64;
            m_tgt[ti] = ex_target;
        end else begin
            m_cnt[bi] = (m_cnt[bi] == 0) ? 0 : m_cnt[bi] - 1;
        end
        if (m_brc != 32'hFFFF_FFFF) m_brc = m_brc + 1;
        if (mp && m_mpc != 32'hFFFF_FFFF) m_mpc = m_mpc + 1;
    endfunction

    initial begin
        logic        ept;
        logic [31:0] eptg;
        logic        emp;
        n_pass = 0;
        n_total = 0;
        rst = 1'b1; if_pc = 32'h1000; ex_valid = 0; ex_is_br = 0; ex_pc = 0;
        ex_br_en = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;

        //            rst ipc       v b pc        en tgt       ept eptgt     e_pt e_ptgt    mp red       brc mpc
        vt.push_back(mk(1, 32'h1000, 0,0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 32'h1004, 0, 32'h0,    0, 0));
        vt.push_back(mk(0, 32'h1000, 0,0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 32'h1004, 0, 32'h0,    0, 0));
        vt.push_back(mk(0, 32'h1000, 1,1, 32'h1000, 1, 32'h0F00, 0, 32'h1004, 0, 32'h1004, 1, 32'h0F00, 1, 1));
        vt.push_back(mk(0, 32'h1000, 0,0, 32'h0,    0, 32'h0,    0, 32'h0,    1, 32'h0F00, 0, 32'h0,    1, 1));
        vt.push_back(mk(0, 32'h1000, 1,1, 32'h1000, 0, 32'h0F00, 1, 32'h0F00, 1, 32'h0F00, 1, 32'h1004, 2, 2));
        vt.push_back(mk(0, 32'h1000, 1,1, 32'h1000, 0, 32'h0F00, 0, 32'h1004, 0, 32'h1004, 0, 32'h0,    3, 2));
        vt.push_back(mk(0, 32'h1000, 1,1, 32'h1000, 0, 32'h0F00, 0, 32'h1004, 0, 32'h1004, 0, 32'h0,    4, 2));
        vt.push_back(mk(0, 32'h1000, 1,1, 32'h1000, 0, 32'h0F00, 0, 32'h1004, 0, 32'h1004, 0, 32'h0,    5, 2));
        vt.push_back(mk(0, 32'h1000, 1,1, 32'h1000, 1, 32'h0F00, 0, 32'h1004, 0, 32'h1004, 1, 32'h0F00, 6, 3));
        vt.push_back(mk(0, 32'h1000, 1,1, 32'h1000, 1, 32'h0F00, 0, 32'h1004, 0, 32'h1004, 1, 32'h0F00, 7, 4));
        vt.push_back(mk(0, 32'h1000, 0,0, 32'h0,    0, 32'h0,    0, 32'h0,    1, 32'h0F00, 0, 32'h0,    7, 4));
        vt.push_back(mk(0, 32'h1000, 1,1, 32'h1040, 1, 32'h0800, 0, 32'h1044, 1, 32'h0F00, 1, 32'h0800, 8, 5));
        vt.push_back(mk(0, 32'h1000, 0,0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 32'h1004, 0, 32'h0,    8, 5));
        vt.push_back(mk(0, 32'h1040, 0,0, 32'h0,    0, 32'h0,    0, 32'h0,    1, 32'h0800, 0, 32'h0,    8, 5));
        vt.push_back(mk(1, 32'h2000, 0,0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 32'h2004, 0, 32'h0,    0, 0));
        vt.push_back(mk(0, 32'h2000, 1,1, 32'h2000, 1, 32'h3000, 0, 32'h2004, 0, 32'h2004, 1, 32'h3000, 1, 1));
        vt.push_back(mk(0, 32'h2000, 1,1, 32'h2000, 1, 32'h3000, 1, 32'h3004, 1, 32'h3000, 1, 32'h3000, 2, 2));
        vt.push_back(mk(0, 32'h2000, 1,1, 32'h2000, 1, 32'h3000, 1, 32'h3000, 1, 32'h3000, 0, 32'h0,    3, 2));
        vt.push_back(mk(1, 32'h2000, 1,1, 32'h4000, 1, 32'h5000, 0, 32'h4004, 0, 32'h2004, 1, 32'h5000, 0, 0));
        vt.push_back(mk(0, 32'h2000, 0,0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 32'h2004, 0, 32'h0,    0, 0));
        vt.push_back(mk(0, 32'h4000, 1,0, 32'h4000, 1, 32'h5000, 0, 32'h4004, 0, 32'h4004, 0, 32'h0,    0, 0));
        vt.push_back(mk(0, 32'h4000, 0,1, 32'h4000, 1, 32'h5000, 0, 32'h4004, 0, 32'h4004, 0, 32'h0,    0, 0));
        vt.push_back(mk(0, 32'h4000, 0,0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 32'h4004, 0, 32'h0,    0, 0));

        foreach (vt[i]) begin
            @(negedge clk);
            rst = vt[i].rst; if_pc = vt[i].if_pc; ex_valid = vt[i].vld; ex_is_br = vt[i].isbr;
            ex_pc = vt[i].pc; ex_br_en = vt[i].en; ex_target = vt[i].tgt;
            ex_pred_taken = vt[i].ept; ex_pred_target = vt[i].eptgt;
            #1;
            chk($sformatf("vec%0d pred_taken", i), {31'd0, pred_taken}, {31'd0, vt[i].e_pt});
            chk($sformatf("vec%0d pred_target", i), pred_target, vt[i].e_ptgt);
            chk($sformatf("vec%0d mispredict", i), {31'd0, mispredict}, {31'd0, vt[i].e_mp});
            if (vt[i].e_mp) chk($sformatf("vec%0d redirect_pc", i), redirect_pc, vt[i].e_red);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d br_count", i), br_count, vt[i].e_brc);
            chk($sformatf("vec%0d mispred_count", i), mispred_count, vt[i].e_mpc);
        end

        m_reset();
        @(negedge clk);
        rst = 1'b1; ex_valid = 0; ex_is_br = 0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 299) == 0);
            if_pc    = 32'h1000 + ($urandom_range(0, 127) << 2);
            ex_valid = ($urandom_range(0, 9) != 0);
            ex_is_br = ($urandom_range(0, 9) > 1);
            ex_pc    = 32'h1000 + ($urandom_range(0, 127) << 2);
            ex_br_en = $urandom_range(0, 1);
            ex_target = ($urandom_range(0, 1) == 1) ? ex_pc + 32'h100 : 32'h0800 + ($urandom_range(0, 15) << 2);
            m_predict(ex_pc, ept, eptg);
            case ($urandom_range(0, 3))
                0: begin ex_pred_taken = $urandom_range(0, 1); ex_pred_target = $urandom; end
                1: begin ex_pred_taken = ept; ex_pred_target = ex_target; end
                default: begin ex_pred_taken = ept; ex_pred_target = eptg; end
            endcase
            #1;
            m_predict(if_pc, ept, eptg);
            if (rst) begin
                ept = 1'b0;
                eptg = if_pc + 32'd4;
            end
            emp = m_misp();
            chk("rand pred_taken", {31'd0, pred_taken}, {31'd0, ept});
            chk("rand pred_target", pred_target, eptg);
            chk("rand mispredict", {31'd0, mispredict}, {31'd0, emp});
            if (emp) chk("rand redirect_pc", redirect_pc, ex_br_en ? ex_target : ex_pc + 32'd4);
            @(posedge clk);
            #1;
            m_edge(emp);
            chk("rand br_count", br_count, m_brc);
            chk("rand mispred_count", mispred_count, m_mpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: BHT_IDX_W, default 6, log2 of branch history table entries, indexed by pc[BHT_IDX_W+1:2].
REQ-002 Parameter: BTB_IDX_W, default 4, log2 of branch target buffer entries, indexed by pc[BTB_IDX_W+1:2].
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: if_pc  input  32  fetch-stage PC to predict.
REQ-006 Port: pred_taken  output  1  predicted taken for if_pc.
REQ-007 Port: pred_target  output  32  predicted next PC for if_pc.
REQ-008 Port: ex_valid  input  1  execute-stage instruction valid this cycle.
REQ-009 Port: ex_is_br  input  1  execute-stage instruction is a conditional branch.
REQ-010 Port: ex_pc  input  32  PC of the resolving branch.
REQ-011 Port: ex_br_en  input  1  resolved outcome, taken when 1 (LSB of the branch comparator result).
REQ-012 Port: ex_target  input  32  computed taken target (ex_pc + B-immediate).
REQ-013 Port: ex_pred_taken  input  1  pred_taken carried down the pipeline with this branch.
REQ-014 Port: ex_pred_target  input  32  pred_target carried down the pipeline with this branch.
REQ-015 Port: mispredict  output  1  flush/redirect request this cycle.
REQ-016 Port: redirect_pc  output  32  correct next PC, valid when mispredict=1.
REQ-017 Port: br_count  output  32  resolved conditional branches since reset.
REQ-018 Port: mispred_count  output  32  mispredictions since reset.

Function
REQ-019 BHT: 2^BHT_IDX_W two-bit saturating counters; states SNT=00, WNT=01, WT=10, ST=11.
REQ-020 BTB: 2^BTB_IDX_W entries; each entry holds valid, tag = pc[31:BTB_IDX_W+2], and a 32-bit target.
REQ-021 Prediction is combinational from if_pc with zero latency: btb_hit = valid && tag match.
REQ-022 pred_taken = btb_hit && BHT counter[1] of the indexed entry.
REQ-023 pred_target = BTB target when pred_taken=1, else if_pc+4 (mod 2^32).
REQ-024 A resolve event occurs when ex_valid && ex_is_br; with no resolve event there are no state updates and mispredict=0.
REQ-025 On a resolve event, mispredict=1 in the same cycle (combinationally) when ex_br_en != ex_pred_taken, or when ex_br_en=1 and ex_pred_target != ex_target.
REQ-026 redirect_pc = ex_target when ex_br_en=1, else ex_pc+4 (mod 2^32); its value when mispredict=0 is don't-care but must be deterministic.
REQ-027 On a resolve event, at the next edge the BHT entry for ex_pc increments (taken) or decrements (not taken), saturating at ST and SNT.
REQ-028 On a resolve event with ex_br_en=1, the BTB entry for ex_pc is written at the next edge: valid=1, tag and target from ex_pc and ex_target, replacing any prior occupant.
REQ-029 Not-taken resolves never write the BTB.
REQ-030 If if_pc and ex_pc index the same entry in the same cycle, prediction uses the pre-update value (read-before-write).
REQ-031 br_count increments on each resolve event; mispred_count increments when mispredict=1; both saturate at 0xFFFF_FFFF.
REQ-032 ex_br_en, ex_target, ex_pred_taken and ex_pred_target are ignored when ex_is_br=0 or ex_valid=0.

Reset
REQ-033 While rst=1 at an edge: all BHT counters become WNT, all BTB valid bits clear, and both counters become 0.
REQ-034 During and after reset: pred_taken=0, pred_target=if_pc+4, and mispredict=0 unless a resolve event is presented.
REQ-035 rst has priority over a simultaneous resolve event; no update from that cycle survives.

Verification
REQ-036 After reset, if_pc=0x0000_1000 -> pred_taken=0, pred_target=0x0000_1004.
REQ-037 One taken resolve, ex_pc=0x1000, ex_target=0x0F00, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x0F00, mispred_count=1; next cycle if_pc=0x1000 -> pred_taken=1 (WT), pred_target=0x0F00.
REQ-038 Four not-taken resolves at 0x1000 after REQ-037 -> counter reaches SNT and stays; pred_taken=0; the BTB entry remains valid.
REQ-039 Alias: BTB holds 0x1000; resolve taken at 0x1040 (same index, different tag) -> if_pc=0x1000 then misses, pred_taken=0.
REQ-040 Same-cycle read/update at 0x2000 in WNT, taken resolve -> pred_taken=0 that cycle, 1 the next cycle; correct taken prediction with wrong ex_pred_target -> mispredict=1.
REQ-041 Resolve event asserted together with rst=1 -> all state is reset values afterward; br_count=0.
